// File: rtl/bram_accessor_pkg.sv
// Shared types for the BRAM accessor pipeline:
// FSM state encoding and per-lane operation codes.
package bram_accessor_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_DRAIN = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    localparam logic [1:0] OP_PASS   = 2'b00;
    localparam logic [1:0] OP_SQUARE = 2'b01;
    localparam logic [1:0] OP_SCALE  = 2'b10;
    localparam logic [1:0] OP_BIAS   = 2'b11;

endpackage

// File: rtl/bram_accessor_pipe_lane.sv
// One registered lane: widens an unsigned input lane to 2x width
// through pass, square, scale or bias.
module lane_core
    import bram_accessor_pkg::*;
#(
    parameter int IN_DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [IN_DATA_WIDTH-1:0]     lane_i,
    input  logic [1:0]                   op_i,
    input  logic [IN_DATA_WIDTH-1:0]     scale_i,
    output logic [2*IN_DATA_WIDTH-1:0]   res_o
);

    localparam int DW = 2 * IN_DATA_WIDTH;

    logic [DW-1:0] a;
    logic [DW-1:0] s;
    logic [DW-1:0] res_d;
    logic [DW-1:0] res_q;

    always_comb begin
        a     = {{IN_DATA_WIDTH{1'b0}}, lane_i};
        s     = {{IN_DATA_WIDTH{1'b0}}, scale_i};
        res_d = '0;
        unique case (op_i)
            OP_PASS:   res_d = a;
            OP_SQUARE: res_d = a * a;
            OP_SCALE:  res_d = a * s;
            OP_BIAS:   res_d = a + s;
            default:   res_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) res_q <= '0;
        else       res_q <= res_d;
    end

    assign res_o = res_q;

endmodule

// File: rtl/bram_accessor_pipe.sv
// Streams a run of words from BRAM0 through NUM_CORE lane cores
// into BRAM1, one word per cycle, pipelined over the read latency.
module bram_accessor_pipe
    import bram_accessor_pkg::*;
#(
    parameter int NUM_CORE      = 4,
    parameter int IN_DATA_WIDTH = 8,
    parameter int DWIDTH_1      = NUM_CORE * IN_DATA_WIDTH,
    parameter int DWIDTH_2      = 2 * DWIDTH_1,
    parameter int AWIDTH        = 8,
    parameter int CNT_BIT       = 9,
    parameter int RD_LAT        = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_run_i,
    input  logic [CNT_BIT-1:0]       run_count_i,
    input  logic [AWIDTH-1:0]        src_base_i,
    input  logic [AWIDTH-1:0]        dst_base_i,
    input  logic [1:0]               op_mode_i,
    input  logic [IN_DATA_WIDTH-1:0] scale_i,
    input  logic [DWIDTH_1-1:0]      q_b0_i,
    output logic                     idle_o,
    output logic                     read_o,
    output logic                     write_o,
    output logic                     done_o,
    output logic [AWIDTH-1:0]        addr_b0_o,
    output logic                     ce_b0_o,
    output logic                     we_b0_o,
    output logic [DWIDTH_1-1:0]      d_b0_o,
    output logic [AWIDTH-1:0]        addr_b1_o,
    output logic                     ce_b1_o,
    output logic                     we_b1_o,
    output logic [DWIDTH_2-1:0]      d_b1_o
);

    localparam int DW = 2 * IN_DATA_WIDTH;
    localparam logic [CNT_BIT-1:0] ONE = 1;
    localparam logic [1:0] DRN_LAST = 2'(RD_LAT);

    state_e                   state_q, state_d;
    logic [CNT_BIT-1:0]       cnt_q, cnt_d;
    logic [CNT_BIT-1:0]       rcnt_q, rcnt_d;
    logic [AWIDTH-1:0]        wcnt_q, wcnt_d;
    logic [AWIDTH-1:0]        src_q, src_d;
    logic [AWIDTH-1:0]        dst_q, dst_d;
    logic [1:0]               op_q, op_d;
    logic [IN_DATA_WIDTH-1:0] scale_q, scale_d;
    logic [1:0]               drn_q, drn_d;
    logic [RD_LAT:0]          vld_q, vld_d;

    logic                     issue;
    logic                     wr;
    logic [DWIDTH_2-1:0]      lane_res;

    assign issue = (state_q == S_RUN);
    assign wr    = vld_q[RD_LAT];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        wcnt_d  = wcnt_q;
        src_d   = src_q;
        dst_d   = dst_q;
        op_d    = op_q;
        scale_d = scale_q;
        drn_d   = drn_q;
        vld_d   = {vld_q[RD_LAT-1:0], issue};
        if (wr) wcnt_d = wcnt_q + 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (start_run_i) begin
                    cnt_d   = run_count_i;
                    src_d   = src_base_i;
                    dst_d   = dst_base_i;
                    op_d    = op_mode_i;
                    scale_d = scale_i;
                    rcnt_d  = '0;
                    wcnt_d  = '0;
                    drn_d   = '0;
                    state_d = (run_count_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                rcnt_d = rcnt_q + ONE;
                if (rcnt_q == cnt_q - ONE) begin
                    state_d = S_DRAIN;
                    drn_d   = '0;
                end
            end
            S_DRAIN: begin
                drn_d = drn_q + 2'd1;
                if (drn_q == DRN_LAST) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            wcnt_q  <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            op_q    <= '0;
            scale_q <= '0;
            drn_q   <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            wcnt_q  <= wcnt_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            op_q    <= op_d;
            scale_q <= scale_d;
            drn_q   <= drn_d;
            vld_q   <= vld_d;
        end
    end

    for (genvar i = 0; i < NUM_CORE; i++) begin : g_lane
        lane_core #(
            .IN_DATA_WIDTH(IN_DATA_WIDTH)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .lane_i (q_b0_i[i*IN_DATA_WIDTH +: IN_DATA_WIDTH]),
            .op_i   (op_q),
            .scale_i(scale_q),
            .res_o  (lane_res[i*DW +: DW])
        );
    end

    // Addresses and write data are gated so idle outputs read as zero.
    assign idle_o    = (state_q == S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign ce_b0_o   = issue;
    assign read_o    = issue;
    assign we_b0_o   = 1'b0;
    assign d_b0_o    = '0;
    assign addr_b0_o = issue ? src_q + rcnt_q[AWIDTH-1:0] : '0;
    assign we_b1_o   = wr;
    assign ce_b1_o   = wr;
    assign write_o   = wr;
    assign addr_b1_o = wr ? dst_q + wcnt_q : '0;
    assign d_b1_o    = wr ? lane_res : '0;

endmodule
